// File: rtl/tiny_band_scheduler.sv
// Time-shares one filter engine across NUM_BANDS bands: each sample is sent once per band,
// responses are accumulated per band and, every WINDOW samples, folded into band_energy.
module tiny_band_scheduler #(
   parameter int NUM_BANDS = 3,
   parameter int ACC_W     = 5,
   parameter int WINDOW    = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sample_tick,
   input  logic [7:0]                 sample_in,
   output logic                       cmd_valid,
   input  logic                       cmd_ready,
   output logic [1:0]                 cmd_band,
   output logic [7:0]                 cmd_sample,
   input  logic                       rsp_valid,
   input  logic [ACC_W-1:0]           rsp_energy,
   output logic [NUM_BANDS*ACC_W-1:0] band_energy,
   output logic                       frame_done,
   output logic                       busy,
   output logic                       overrun,
   input  logic                       clr_ovr
);

   // state    | meaning
   // IDLE     | waiting for sample_tick
   // ISSUE    | command for band_idx offered to the engine
   // WAIT_RSP | command accepted, waiting for its response
   // PUBLISH  | fold accumulators into band_energy, start a new frame
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ISSUE    = 2'd1;
   localparam logic [1:0] S_WAIT_RSP = 2'd2;
   localparam logic [1:0] S_PUBLISH  = 2'd3;

   localparam int              WC_W      = $clog2(WINDOW);
   localparam logic [1:0]      LAST_BAND = 2'(NUM_BANDS - 1);
   localparam logic [WC_W-1:0] LAST_WIN  = WC_W'(WINDOW - 1);
   localparam logic [ACC_W:0]  ACC_MAX   = {1'b0, {ACC_W{1'b1}}};

   logic [1:0]       state_q, state_d;
   logic [1:0]       band_idx_q, band_idx_d;
   logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [1:0]       cmd_band_q, cmd_band_d;
   logic [7:0]       cmd_sample_q, cmd_sample_d;
   logic             frame_done_q, frame_done_d;
   logic             overrun_q, overrun_d;
   logic [ACC_W-1:0] acc_q [NUM_BANDS];
   logic [ACC_W-1:0] acc_d [NUM_BANDS];
   logic [ACC_W-1:0] energy_q [NUM_BANDS];
   logic [ACC_W-1:0] energy_d [NUM_BANDS];

   logic [ACC_W-1:0] acc_sel;
   logic [ACC_W:0]   acc_sum;
   logic [ACC_W-1:0] acc_sat;
   logic             drop;

   always_comb begin
      acc_sel = '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
         if (band_idx_q == 2'(b)) acc_sel = acc_q[b];
      end
      acc_sum = {1'b0, acc_sel} + {1'b0, rsp_energy};
      acc_sat = (acc_sum > ACC_MAX) ? ACC_MAX[ACC_W-1:0] : acc_sum[ACC_W-1:0];
   end

   always_comb begin
      state_d      = state_q;
      band_idx_d   = band_idx_q;
      win_cnt_d    = win_cnt_q;
      cmd_valid_d  = cmd_valid_q;
      cmd_band_d   = cmd_band_q;
      cmd_sample_d = cmd_sample_q;
      acc_d        = acc_q;
      energy_d     = energy_q;
      frame_done_d = (state_q == S_PUBLISH);
      // ticks are only taken in IDLE; anything else is a drop, and a drop beats clr_ovr
      drop         = sample_tick && (state_q != S_IDLE);
      overrun_d    = drop || (overrun_q && !clr_ovr);

      case (state_q)
         S_IDLE: begin
            if (sample_tick) begin
               cmd_sample_d = sample_in;
               band_idx_d   = 2'd0;
               cmd_band_d   = 2'd0;
               cmd_valid_d  = 1'b1;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (cmd_valid_q && cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            if (rsp_valid) begin
               for (int b = 0; b < NUM_BANDS; b++) begin
                  if (band_idx_q == 2'(b)) acc_d[b] = acc_sat;
               end
               if (band_idx_q < LAST_BAND) begin
                  band_idx_d  = band_idx_q + 2'd1;
                  cmd_band_d  = band_idx_q + 2'd1;
                  cmd_valid_d = 1'b1;
                  state_d     = S_ISSUE;
               end else if (win_cnt_q == LAST_WIN) begin
                  state_d = S_PUBLISH;
               end else begin
                  win_cnt_d = win_cnt_q + WC_W'(1);
                  state_d   = S_IDLE;
               end
            end
         end
         S_PUBLISH: begin
            // each half is below 2^(ACC_W-1), so the sum cannot overflow
            for (int b = 0; b < NUM_BANDS; b++) begin
               energy_d[b] = (energy_q[b] >> 1) + (acc_q[b] >> 1);
               acc_d[b]    = '0;
            end
            win_cnt_d = '0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         band_idx_q   <= '0;
         win_cnt_q    <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_band_q   <= '0;
         cmd_sample_q <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         for (int b = 0; b < NUM_BANDS; b++) begin
            acc_q[b]    <= '0;
            energy_q[b] <= '0;
         end
      end else begin
         state_q      <= state_d;
         band_idx_q   <= band_idx_d;
         win_cnt_q    <= win_cnt_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_band_q   <= cmd_band_d;
         cmd_sample_q <= cmd_sample_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
         for (int b = 0; b < NUM_BANDS; b++) begin
            acc_q[b]    <= acc_d[b];
            energy_q[b] <= energy_d[b];
         end
      end
   end

   always_comb begin
      band_energy = '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
         band_energy[ACC_W*b +: ACC_W] = energy_q[b];
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_band   = cmd_band_q;
   assign cmd_sample = cmd_sample_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != S_IDLE);

endmodule
